// File: rtl/adder_bist.sv
// Built-in self-test for a ripple-carry adder: exhaustive {a,b,c_in} sweep,
// latency-aligned response check, error count and first failing vector capture.
module adder_bist #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 c_in,
    input  logic [WIDTH-1:0]     s,
    input  logic                 c_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     first_fail_vec,
    output logic                 first_fail_vld
);

    localparam int unsigned VW = 2 * WIDTH + 1;
    localparam int unsigned EW = 2 * WIDTH + 2;
    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned DW = 3;
    localparam logic [VW-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            start_acc;
    logic [VW-1:0]   vec_q;
    logic [DW-1:0]   drain_q;
    logic            chk_vld;
    logic [VW-1:0]   chk_vec;
    logic [SW-1:0]   exp_sum;
    logic            mismatch;
    logic [EW-1:0]   err_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only accepted outside a sweep
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (vec_q == VEC_LAST) begin
                    state_d = (LATENCY > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(LATENCY - 1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Align each driven vector with the adder response it produces
    if (LATENCY == 0) begin : g_comb
        assign chk_vld = (state_q == S_RUN);
        assign chk_vec = vec_q;
    end else begin : g_pipe
        logic          vld_q  [LATENCY];
        logic [VW-1:0] pvec_q [LATENCY];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(LATENCY); i++) begin
                    vld_q[i]  <= 1'b0;
                    pvec_q[i] <= '0;
                end
            end else begin
                vld_q[0]  <= (state_q == S_RUN);
                pvec_q[0] <= vec_q;
                for (int i = 1; i < int'(LATENCY); i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    pvec_q[i] <= pvec_q[i-1];
                end
            end
        end

        assign chk_vld = vld_q[LATENCY-1];
        assign chk_vec = pvec_q[LATENCY-1];
    end

    assign exp_sum  = SW'(chk_vec[VW-1 -: WIDTH]) + SW'(chk_vec[WIDTH:1]) + SW'(chk_vec[0]);
    assign mismatch = chk_vld && (exp_sum != {c_out, s});

    always_comb begin
        err_d = err_count;
        if (start_acc) begin
            err_d = '0;
        end else if (mismatch) begin
            err_d = err_count + EW'(1);
        end
    end

    // Stimulus counter, drain timer, result and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q          <= '0;
            drain_q        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            if (start_acc) begin
                vec_q <= '0;
            end else if (state_q == S_RUN && vec_q != VEC_LAST) begin
                vec_q <= vec_q + VW'(1);
            end

            if (state_q == S_DRAIN) begin
                drain_q <= drain_q + DW'(1);
            end else begin
                drain_q <= '0;
            end

            err_count <= err_d;
            if (start_acc) begin
                first_fail_vld <= 1'b0;
            end else if (mismatch && !first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_vec <= chk_vec;
            end

            busy <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done <= (state_d == S_DONE);
            pass <= (state_d == S_DONE) && (err_d == '0);
        end
    end

    assign a    = vec_q[VW-1 -: WIDTH];
    assign b    = vec_q[WIDTH:1];
    assign c_in = vec_q[0];

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: two instances (LATENCY 0 and 1) around a fault-injectable
// adder, checked every cycle against a sweep-position model plus literal pins.
module tb_adder_bist;

    localparam int NV = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    logic [3:0] a0, b0, s0, a1, b1, s1;
    logic       ci0, co0, ci1, co1;
    logic       busy0, done0, pass0, ffvld0, busy1, done1, pass1, ffvld1;
    logic [9:0] err0, err1;
    logic [8:0] ffv0, ffv1;

    int   fault_mode, fault_bit, fault_vec;
    logic fault_val;
    logic reg_mode0;
    logic [4:0] r0_q, r1_q;

    int n_chk  = 0;
    int n_fail = 0;

    int  t_m     [2];
    int  pre_m   [2][0:NV];
    int  first_m [2];
    bit  chk_en  [2];
    bit  mdl_on  = 1'b0;

    // Adder under test with optional injected fault
    function automatic logic [4:0] add_fn(input logic [8:0] v, input int mode, input int fb,
                                          input logic fv, input int fvec);
        logic [4:0] r;
        r = 5'(v[8:5]) + 5'(v[4:1]) + 5'(v[0]);
        case (mode)
            1: r[0] = 1'b0;
            2: r[4] = 1'b0;
            3: r[fb] = fv;
            4: if (int'(v) == fvec) r[fb] = ~r[fb];
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        r0_q <= add_fn({a0, b0, ci0}, fault_mode, fault_bit, fault_val, fault_vec);
        r1_q <= add_fn({a1, b1, ci1}, fault_mode, fault_bit, fault_val, fault_vec);
    end
    assign {co0, s0} = reg_mode0 ? r0_q : add_fn({a0, b0, ci0}, fault_mode, fault_bit, fault_val, fault_vec);
    assign {co1, s1} = r1_q;

    adder_bist #(.WIDTH(4), .LATENCY(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .a(a0), .b(b0), .c_in(ci0), .s(s0), .c_out(co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_vld(ffvld0));

    adder_bist #(.WIDTH(4), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .a(a1), .b(b1), .c_in(ci1), .s(s1), .c_out(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_vld(ffvld1));

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, got, exp);
        end
    endtask

    // Mismatch table for a fresh sweep: prefix counts and first failing vector
    task automatic build(input int d);
        pre_m[d][0] = 0;
        first_m[d]  = -1;
        for (int v = 0; v < NV; v++) begin
            logic bad;
            bad = add_fn(9'(v), fault_mode, fault_bit, fault_val, fault_vec) !=
                  add_fn(9'(v), 0, 0, 1'b0, 0);
            pre_m[d][v+1] = pre_m[d][v] + (bad ? 1 : 0);
            if (bad && first_m[d] < 0) first_m[d] = v;
        end
    endtask

    // Model: t = edges since the accepted start (-1 = idle after reset)
    always @(posedge clk) begin
        if (rst) begin
            mdl_on = 1'b1;
            t_m[0] = -1;
            t_m[1] = -1;
        end else if (mdl_on) begin
            for (int d = 0; d < 2; d++) begin
                if (start && (t_m[d] < 0 || t_m[d] >= NV + d)) begin
                    t_m[d] = 0;
                    build(d);
                end else if (t_m[d] >= 0 && t_m[d] < 100000) begin
                    t_m[d]++;
                end
            end
        end
    end

    task automatic cmp_dut(input int d, input logic bz, input logic dn, input logic ps,
                           input logic [8:0] v, input logic [9:0] e, input logic fl,
                           input logic [8:0] fv);
        int t, k, ee;
        logic [8:0] ev;
        logic eb, ep;
        t = t_m[d];
        if (t < 0) begin
            ev = '0; eb = 1'b0; ep = 1'b0; ee = 0;
        end else begin
            ev = (t < NV) ? 9'(t) : 9'(NV - 1);
            eb = (t < NV + d);
            k  = t - d;
            if (k < 0) k = 0;
            if (k > NV) k = NV;
            ee = pre_m[d][k];
            ep = !eb && (pre_m[d][NV] == 0);
        end
        chk("busy", d, 32'(bz), 32'(eb));
        chk("done", d, 32'(dn), 32'(t >= 0 && !eb));
        chk("pass", d, 32'(ps), 32'(ep));
        chk("vector", d, 32'(v), 32'(ev));
        chk("err_count", d, 32'(e), 32'(ee));
        chk("first_fail_vld", d, 32'(fl), 32'(ee != 0));
        if (ee != 0) chk("first_fail_vec", d, 32'(fv), 32'(first_m[d]));
    endtask

    always @(negedge clk) begin
        if (mdl_on) begin
            if (chk_en[0]) cmp_dut(0, busy0, done0, pass0, {a0, b0, ci0}, err0, ffvld0, ffv0);
            if (chk_en[1]) cmp_dut(1, busy1, done1, pass1, {a1, b1, ci1}, err1, ffvld1, ffv1);
        end
    end

    // One sweep; optional ignored re-start and mid-sweep reset; returns done latencies
    task automatic run_sweep(input int rst_at, input int repulse, output int c0, output int c1);
        int cyc;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_clears_done", 0, 32'(done0), 32'd0);
        c0 = -1; c1 = -1; cyc = 0;
        while ((c0 < 0 || c1 < 0) && cyc < 2000) begin
            if (cyc == repulse) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done0 && c0 < 0) c0 = cyc;
            if (done1 && c1 < 0) c1 = cyc;
            if (cyc == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", 0, 32'(busy0), 32'd0);
                chk("abort_done", 0, 32'(done0), 32'd0);
                chk("abort_vec", 0, 32'({a0, b0, ci0}), 32'd0);
                chk("abort_err", 0, 32'(err0), 32'd0);
                c0 = 0; c1 = 0;
                return;
            end
        end
        if (c0 < 0 || c1 < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: done0=%0b done1=%0b after %0d cycles, required done", done0, done1, cyc);
        end
    endtask

    initial begin
        int c0, c1;
        rst = 1'b1; start = 1'b0; reg_mode0 = 1'b0;
        fault_mode = 0; fault_bit = 0; fault_val = 1'b0; fault_vec = 0;
        chk_en[0] = 1'b1; chk_en[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, 32'(busy0), 32'd0);
        chk("rst_err", 0, 32'(err0), 32'd0);
        chk("rst_vec", 0, 32'({a0, b0, ci0}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fault-free adder
        run_sweep(-1, -1, c0, c1);
        chk("done_latency", 0, 32'(c0), 32'd512);
        chk("done_latency", 1, 32'(c1), 32'd513);
        chk("pass_good", 0, 32'(pass0), 32'd1);
        chk("pass_good", 1, 32'(pass1), 32'd1);
        chk("ffvld_good", 0, 32'(ffvld0), 32'd0);

        // s[0] stuck at 0
        fault_mode = 1;
        run_sweep(-1, -1, c0, c1);
        chk("s0_err", 0, 32'(err0), 32'd256);
        chk("s0_first", 0, 32'(ffv0), 32'h001);
        chk("s0_vld", 0, 32'(ffvld0), 32'd1);
        chk("s0_pass", 0, 32'(pass0), 32'd0);
        chk("s0_err", 1, 32'(err1), 32'd256);

        // c_out stuck at 0
        fault_mode = 2;
        run_sweep(-1, -1, c0, c1);
        chk("cout_err", 0, 32'(err0), 32'd256);
        chk("cout_first", 0, 32'(ffv0), 32'h01F);
        chk("cout_first", 1, 32'(ffv1), 32'h01F);

        // Registered adder seen by a zero-latency checker
        fault_mode = 0;
        chk_en[0] = 1'b0;
        reg_mode0 = 1'b1;
        run_sweep(-1, -1, c0, c1);
        chk("lat_mismatch_err_nonzero", 0, 32'(err0 != 10'd0), 32'd1);
        chk("lat_mismatch_pass", 0, 32'(pass0), 32'd0);
        chk("lat_match_pass", 1, 32'(pass1), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        reg_mode0 = 1'b0;
        chk_en[0] = 1'b1;

        // Reset mid-sweep, then a clean sweep
        fault_mode = 1;
        run_sweep(100, -1, c0, c1);
        fault_mode = 0;
        run_sweep(-1, -1, c0, c1);
        chk("after_abort_pass", 0, 32'(pass0), 32'd1);

        // start ignored while busy; restart from DONE
        run_sweep(-1, 50, c0, c1);
        chk("repulse_latency", 0, 32'(c0), 32'd512);
        run_sweep(-1, -1, c0, c1);
        chk("restart_latency", 0, 32'(c0), 32'd512);

        // Randomized faults, gaps, re-starts and resets
        for (int it = 0; it < 6; it++) begin
            int rat;
            fault_mode = int'($urandom_range(0, 4));
            fault_bit  = int'($urandom_range(0, 4));
            fault_val  = 1'($urandom_range(0, 1));
            fault_vec  = int'($urandom_range(0, NV - 1));
            rat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 510)) : -1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_sweep(rat, int'($urandom_range(1, 500)), c0, c1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
- Hardware stimulus generator and response checker (built-in self-test) for the generate-based ripple-carry `adder`.
- Drives the adder's `a`, `b` and `c_in` inputs with an exhaustive sweep of every input vector.
- Samples the adder's `s` and `c_out` responses and compares each against an internally computed expected sum.
- Reports the mismatch count and the first failing vector, so the adder can be self-checked in silicon or in a bench without console dumps.

Parameters:
- WIDTH, 4, operand width of the adder under test (1..8).
- LATENCY, 0, register stages between adder inputs and outputs (0..7); 0 = combinational adder.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle pulse that begins a sweep.
- a  output  WIDTH  operand A to the adder.
- b  output  WIDTH  operand B to the adder.
- c_in  output  1  carry in to the adder.
- s  input  WIDTH  sum returned by the adder.
- c_out  input  1  carry out returned by the adder.
- busy  output  1  sweep or drain in progress.
- done  output  1  sweep complete; held until the next accepted start or rst.
- pass  output  1  done and err_count == 0.
- err_count  output  2*WIDTH+2  number of mismatching vectors.
- first_fail_vec  output  2*WIDTH+1  {a,b,c_in} of the first mismatch.
- first_fail_vld  output  1  first_fail_vec holds a captured vector.

Behaviour:
- Reset (rst=1 at a clk edge, in any state, including mid-sweep):
  - State returns to IDLE.
  - a, b, c_in, busy, done, pass, err_count, first_fail_vec and first_fail_vld are all 0.
  - The check pipeline valid bits are cleared.
- Vector counter vec has width 2*WIDTH+1 and maps as {a,b,c_in} = vec (a in MSBs). N = 2^(2*WIDTH+1) vectors (512 for WIDTH=4).
- State machine:
  - IDLE: start=1 → RUN; vec<=0; err_count, first_fail_vld and done are cleared.
  - RUN: drives vec; vec<=vec+1 each cycle. When vec==N-1 is being driven: → DRAIN if LATENCY>0, otherwise → DONE.
  - DRAIN: waits LATENCY cycles, then → DONE.
  - DONE: done=1. start=1 restarts the sweep exactly as from IDLE.
- start is ignored while busy (RUN or DRAIN).
- busy = (state==RUN || state==DRAIN).
- a, b and c_in are registered. They hold the last driven vector after the sweep and are 0 only after rst.
- Check pipeline:
  - Depth LATENCY shift register of {valid, vector}.
  - A vector driven in cycle k is compared at the edge ending cycle k+LATENCY.
  - Expected value = a + b + c_in, zero-extended to WIDTH+1 bits, compared with {c_out,s}.
- On a valid mismatch, err_count increments. If first_fail_vld==0, first_fail_vec<=vector and first_fail_vld<=1.
- err_count cannot overflow: its maximum is N, which needs 2*WIDTH+2 bits.
- Timing: with start sampled at edge E0, vector 0 appears after E0. done rises after edge E(N+LATENCY), i.e. N+LATENCY cycles after the start edge.
- pass is registered together with done.
- Simultaneous rst and start: rst wins.

Test Plan:
- Fault-free combinational adder, WIDTH=4, LATENCY=0, one start pulse → busy for 512 cycles; done rises 512 cycles after the start edge; err_count=0; pass=1; first_fail_vld=0.
- Adder s[0] forced to 0 → err_count=256; first_fail_vec=9'h001 (a=0,b=0,c_in=1); first_fail_vld=1; pass=0.
- Adder c_out forced to 0 → err_count=256; first_fail_vec=9'h01F (a=0,b=15,c_in=1).
- Adder outputs registered once, LATENCY=1 → done rises 513 cycles after start; err_count=0; pass=1. The same adder checked with LATENCY=0 → err_count>0 and pass=0.
- rst asserted at cycle 100 of a sweep → next cycle busy=0, done=0, a=b=c_in=0, err_count=0. A following start completes normally with pass=1.
- start re-pulsed at cycle 50 of a sweep → ignored; done still rises at cycle 512. start pulsed in DONE → done drops next cycle and a fresh 512-cycle sweep runs.
